// File: rtl/sort_fuc_pkg.sv
// Shared sizing defaults and scheduler state encoding for the sort counting unit.
package sort_fuc_pkg;

  localparam int SORT_FUC_MAX_NUM           = 1024;
  localparam int SORT_FUC_BK_NUM            = 4;
  localparam int SORT_FUC_CNT_MEM_DEPTH     = SORT_FUC_MAX_NUM / SORT_FUC_BK_NUM;
  localparam int SORT_FUC_CNT_MEM_DEPTH_W   = $clog2(SORT_FUC_CNT_MEM_DEPTH);
  localparam int SCH_CREDIT_NUM             = 4;
  localparam int SCH_CREDIT_W               = $clog2(SCH_CREDIT_NUM + 1);
  localparam int SCH_RD_LAT                 = 2;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_DRAIN = 2'd1,
    SCH_SCAN  = 2'd2,
    SCH_FLUSH = 2'd3
  } sch_state_e;

endpackage

// File: rtl/sort_sch_credit_cnt.sv
// Saturating up/down counter; flags an increment at MAX_VAL or a decrement at zero.
module sort_sch_credit_cnt #(
  parameter int MAX_VAL  = 4,
  parameter int W        = 3,
  parameter int INIT_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         unf
);

  logic at_max;
  logic at_zero;

  assign at_max  = (cnt == W'(MAX_VAL));
  assign at_zero = (cnt == '0);
  assign ovf     = inc && !dec && at_max;
  assign unf     = dec && !inc && at_zero;

  // Simultaneous inc and dec cancel; out-of-range steps hold the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= W'(INIT_VAL);
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !at_zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sort_cnt_rd_sched.sv
// Count-memory readout scheduler: hold AGU, drain the count pipe, then stream
// credit-gated read+clear requests over every cnt-mem address.
module sort_cnt_rd_sched
  import sort_fuc_pkg::*;
#(
  parameter int CNT_MEM_DEPTH = SORT_FUC_CNT_MEM_DEPTH,
  parameter int DEPTH_W       = $clog2(CNT_MEM_DEPTH),
  parameter int CREDIT_NUM    = SCH_CREDIT_NUM,
  parameter int RD_LAT        = SCH_RD_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl2sch_start_i,
  input  logic               ctrl2sch_abort_i,
  input  logic               cntu2sch_wr_done_i,
  input  logic               cnt2sch_rd_vld_i,
  input  logic               pru2sch_credit_rtn_i,
  output logic               sch2agu_hold_o,
  output logic               sch2cnt_rd_vld_o,
  output logic [DEPTH_W-1:0] sch2cnt_rd_addr_o,
  output logic               sch2ctrl_busy_o,
  output logic               sch2ctrl_done_o,
  output logic               sch2ctrl_aborted_o,
  output logic               sch2ctrl_err_o
);

  localparam int CREDIT_W  = $clog2(CREDIT_NUM + 1);
  localparam int OUTST_MAX = CREDIT_NUM + RD_LAT;
  localparam int OUTST_W   = $clog2(OUTST_MAX + 1);

  sch_state_e          state_q, state_d;
  logic [DEPTH_W-1:0]  addr_q, addr_d;
  logic [CREDIT_W-1:0] credits;
  logic [OUTST_W-1:0]  outst;
  logic                issue;
  logic                clr_flags;
  logic                set_abort;
  logic                done_d;
  logic                cred_ovf, cred_unf;
  logic                outst_ovf, outst_unf;
  logic                err_evt;

  assign issue   = (state_q == SCH_SCAN) && (credits != '0) && !ctrl2sch_abort_i;
  assign err_evt = cred_ovf || cred_unf || outst_ovf || outst_unf;

  assign sch2cnt_rd_vld_o  = issue;
  assign sch2cnt_rd_addr_o = addr_q;

  // Credits persist across scans: the PRU may still be draining the previous one.
  sort_sch_credit_cnt #(
    .MAX_VAL  (CREDIT_NUM),
    .W        (CREDIT_W),
    .INIT_VAL (CREDIT_NUM)
  ) u_credit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pru2sch_credit_rtn_i),
    .dec (issue),
    .cnt (credits),
    .ovf (cred_ovf),
    .unf (cred_unf)
  );

  sort_sch_credit_cnt #(
    .MAX_VAL  (OUTST_MAX),
    .W        (OUTST_W),
    .INIT_VAL (0)
  ) u_outst_cnt (
    .clk (clk),
    .rst (rst),
    .inc (issue),
    .dec (cnt2sch_rd_vld_i),
    .cnt (outst),
    .ovf (outst_ovf),
    .unf (outst_unf)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    clr_flags = 1'b0;
    set_abort = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (ctrl2sch_start_i) begin
          state_d   = SCH_DRAIN;
          addr_d    = '0;
          clr_flags = 1'b1;
        end
      end
      SCH_DRAIN: begin
        if (ctrl2sch_abort_i) begin
          state_d   = SCH_FLUSH;
          set_abort = 1'b1;
        end else if (cntu2sch_wr_done_i) begin
          state_d = SCH_SCAN;
        end
      end
      SCH_SCAN: begin
        if (ctrl2sch_abort_i) begin
          state_d   = SCH_FLUSH;
          set_abort = 1'b1;
        end else if (issue) begin
          if (addr_q == DEPTH_W'(CNT_MEM_DEPTH - 1)) begin
            state_d = SCH_FLUSH;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      SCH_FLUSH: begin
        if (outst == '0) begin
          state_d = SCH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // Hold/busy track the next state so the AGU is blocked from the cycle after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= SCH_IDLE;
      addr_q             <= '0;
      sch2agu_hold_o     <= 1'b0;
      sch2ctrl_busy_o    <= 1'b0;
      sch2ctrl_done_o    <= 1'b0;
      sch2ctrl_aborted_o <= 1'b0;
      sch2ctrl_err_o     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      sch2agu_hold_o  <= (state_d != SCH_IDLE);
      sch2ctrl_busy_o <= (state_d != SCH_IDLE);
      sch2ctrl_done_o <= done_d;
      if (clr_flags) begin
        sch2ctrl_aborted_o <= 1'b0;
      end else if (set_abort) begin
        sch2ctrl_aborted_o <= 1'b1;
      end
      if (err_evt) begin
        sch2ctrl_err_o <= 1'b1;
      end else if (clr_flags) begin
        sch2ctrl_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_cnt_rd_sched.sv
// Directed bench for sort_cnt_rd_sched with a 2-cycle count-unit return model.
module tb_sort_cnt_rd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctrl2sch_start_i = 1'b0;
  logic       ctrl2sch_abort_i = 1'b0;
  logic       cntu2sch_wr_done_i = 1'b0;
  logic       cnt2sch_rd_vld_i = 1'b0;
  logic       pru2sch_credit_rtn_i = 1'b0;
  logic       sch2agu_hold_o;
  logic       sch2cnt_rd_vld_o;
  logic [7:0] sch2cnt_rd_addr_o;
  logic       sch2ctrl_busy_o;
  logic       sch2ctrl_done_o;
  logic       sch2ctrl_aborted_o;
  logic       sch2ctrl_err_o;

  int checks = 0;
  int errors = 0;

  logic [1:0] pipe = 2'b00;
  logic       rtn_en = 1'b0;
  logic       force_rtn = 1'b0;
  logic       iss, s_done, s_aborted, s_err, s_hold, s_busy;
  int         n_iss, exp_addr, addr_bad, last_addr;
  int         n, k;

  sort_cnt_rd_sched dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl2sch_start_i     (ctrl2sch_start_i),
    .ctrl2sch_abort_i     (ctrl2sch_abort_i),
    .cntu2sch_wr_done_i   (cntu2sch_wr_done_i),
    .cnt2sch_rd_vld_i     (cnt2sch_rd_vld_i),
    .pru2sch_credit_rtn_i (pru2sch_credit_rtn_i),
    .sch2agu_hold_o       (sch2agu_hold_o),
    .sch2cnt_rd_vld_o     (sch2cnt_rd_vld_o),
    .sch2cnt_rd_addr_o    (sch2cnt_rd_addr_o),
    .sch2ctrl_busy_o      (sch2ctrl_busy_o),
    .sch2ctrl_done_o      (sch2ctrl_done_o),
    .sch2ctrl_aborted_o   (sch2ctrl_aborted_o),
    .sch2ctrl_err_o       (sch2ctrl_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample the cycle's outputs, then drive count-unit returns two edges after each issue.
  task automatic step();
    #1;
    iss       = sch2cnt_rd_vld_o;
    s_done    = sch2ctrl_done_o;
    s_aborted = sch2ctrl_aborted_o;
    s_err     = sch2ctrl_err_o;
    s_hold    = sch2agu_hold_o;
    s_busy    = sch2ctrl_busy_o;
    if (iss) begin
      if (int'(sch2cnt_rd_addr_o) != exp_addr) addr_bad++;
      last_addr = int'(sch2cnt_rd_addr_o);
      exp_addr++;
      n_iss++;
    end
    pipe = {pipe[0], iss};
    @(negedge clk);
    cnt2sch_rd_vld_i     = pipe[1];
    pru2sch_credit_rtn_i = (rtn_en & pipe[1]) | force_rtn;
  endtask

  task automatic new_test();
    n_iss = 0; exp_addr = 0; addr_bad = 0; last_addr = -1;
  endtask

  task automatic start_scan();
    ctrl2sch_start_i = 1'b1;
    step();
    ctrl2sch_start_i = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output int cyc);
    cyc = 0;
    s_done = 1'b0;
    while (!s_done && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_abort();
    ctrl2sch_abort_i = 1'b1;
    step();
    ctrl2sch_abort_i = 1'b0;
  endtask

  initial begin
    new_test();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", sch2ctrl_busy_o, 0);
    check("rst_hold", sch2agu_hold_o, 0);
    check("rst_rd_vld", sch2cnt_rd_vld_o, 0);
    check("rst_addr", sch2cnt_rd_addr_o, 0);
    check("rst_done", sch2ctrl_done_o, 0);
    check("rst_err", sch2ctrl_err_o, 0);
    check("rst_aborted", sch2ctrl_aborted_o, 0);

    // Full scan with credits returned two cycles after each issue.
    new_test();
    cntu2sch_wr_done_i = 1'b1;
    rtn_en = 1'b1;
    start_scan();
    run_to_done(400, n);
    check("t1_done", s_done, 1);
    check("t1_cycles", n, 261);
    check("t1_reads", n_iss, 256);
    check("t1_addr_seq", addr_bad, 0);
    check("t1_last_addr", last_addr, 255);
    check("t1_err", s_err, 0);
    check("t1_aborted", s_aborted, 0);
    step();
    check("t1_done_pulse", s_done, 0);
    check("t1_busy_after", s_busy, 0);

    // Drain waits for the count unit to go idle.
    new_test();
    cntu2sch_wr_done_i = 1'b0;
    start_scan();
    step();
    check("t2_hold_clk1", s_hold, 1);
    check("t2_busy_clk1", s_busy, 1);
    repeat (3) step();
    cntu2sch_wr_done_i = 1'b1;
    step();
    check("t2_no_issue_in_drain", n_iss, 0);
    step();
    check("t2_first_issue", iss, 1);
    check("t2_first_addr", last_addr, 0);
    do_abort();
    run_to_done(20, n);
    check("t2_done", s_done, 1);
    check("t2_aborted", s_aborted, 1);

    // Credit stall: four reads then stop until a credit comes back.
    new_test();
    rtn_en = 1'b0;
    start_scan();
    repeat (12) step();
    check("t3_stall_reads", n_iss, 4);
    check("t3_stall_last", last_addr, 3);
    force_rtn = 1'b1;
    step();
    force_rtn = 1'b0;
    repeat (4) step();
    check("t3_one_more_read", n_iss, 5);
    check("t3_addr4", last_addr, 4);
    check("t3_addr_seq", addr_bad, 0);
    do_abort();
    run_to_done(20, n);
    check("t3_done", s_done, 1);
    check("t3_aborted", s_aborted, 1);
    check("t3_err", s_err, 0);
    force_rtn = 1'b1;
    repeat (4) step();
    force_rtn = 1'b0;
    step();
    check("t3_refill_no_err", s_err, 0);

    // Abort while the address register holds 100.
    new_test();
    rtn_en = 1'b1;
    start_scan();
    k = 0;
    while (last_addr != 99 && k < 200) begin
      step();
      k++;
    end
    check("t4_reached_99", last_addr, 99);
    do_abort();
    check("t4_no_issue_on_abort", iss, 0);
    run_to_done(20, n);
    check("t4_done_cycles", n, 3);
    check("t4_reads", n_iss, 100);
    check("t4_last_addr", last_addr, 99);
    check("t4_aborted", s_aborted, 1);
    check("t4_err", s_err, 0);

    // Credit return with a full pool raises sticky err; start clears it.
    new_test();
    force_rtn = 1'b1;
    step();
    force_rtn = 1'b0;
    repeat (2) step();
    check("t5_err_set", s_err, 1);
    repeat (3) step();
    check("t5_err_held", s_err, 1);
    check("t5_idle", s_busy, 0);
    start_scan();
    step();
    check("t5_err_cleared", s_err, 0);
    do_abort();
    run_to_done(20, n);
    check("t5_done", s_done, 1);
    check("t5_err_end", s_err, 0);

    // Asynchronous reset mid-scan, then a clean rescan.
    new_test();
    start_scan();
    k = 0;
    while (last_addr != 49 && k < 200) begin
      step();
      k++;
    end
    check("t6_reached_49", last_addr, 49);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", sch2ctrl_busy_o, 0);
    check("t6_rst_hold", sch2agu_hold_o, 0);
    check("t6_rst_rd_vld", sch2cnt_rd_vld_o, 0);
    check("t6_rst_addr", sch2cnt_rd_addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    pipe = 2'b00;
    cnt2sch_rd_vld_i = 1'b0;
    pru2sch_credit_rtn_i = 1'b0;
    new_test();
    start_scan();
    run_to_done(400, n);
    check("t6_done", s_done, 1);
    check("t6_cycles", n, 261);
    check("t6_reads", n_iss, 256);
    check("t6_addr_seq", addr_bad, 0);
    check("t6_err", s_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
